// File: rtl/ex_div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, result held in DONE until the memory stage releases it.
module ex_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;   // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             sign_q, sign_r;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             last_iter;
    logic             div_zero;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;

    assign rem_sh    = {rem, dvd[WIDTH-1]};
    assign trial     = rem_sh - {1'b0, dvs};
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign div_zero  = (divisor == '0);

    assign dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign busy = (state == RUN) || (state == SIGN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = div_zero ? DONE : RUN;
            RUN:  if (last_iter) state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (div_zero) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        dvd    <= dividend_abs;
                        dvs    <= divisor_abs;
                        rem    <= '0;
                        cnt    <= '0;
                        sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= is_signed & dividend[WIDTH-1];
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // A restore never needs bit WIDTH: when it is set the subtract succeeds.
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                end
                SIGN: begin
                    quotient    <= sign_q ? -dvd : dvd;
                    remainder   <= sign_r ? -rem : rem;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
